nec_ir_decoder: RTL and testbench
=================================

Name: nec_ir_decoder

Overview:
- Fabric-side front end for the IR remote subsystem: samples the demodulated output of the IR receiver module, times mark/space widths and decodes NEC frames (leader, 32 data bits, stop mark, repeat codes).
- Validated address/command bytes go out through a one-deep valid/ready register, consumed by the MSS-side fabric interface that forwards them to firmware (UART_0 reporting path).

Parameters:
- TICK_CYCLES, 2000, FAB_CLK cycles per 50 us timing tick (40 MHz default).
- TIMEOUT_TICKS, 220, ticks without an edge in a non-IDLE state before the frame is aborted.

Ports:
- FAB_CLK  input  1  fabric clock, all logic on rising edge.
- FAB_RESET  input  1  synchronous, active-high reset.
- IR_IN  input  1  asynchronous demodulated IR, active-low (0 = mark/carrier present).
- IR_READY  input  1  downstream accepts the output word.
- IR_VALID  output  1  output word valid.
- IR_ADDR  output  8  NEC address byte.
- IR_CMD  output  8  NEC command byte.
- IR_REPEAT  output  1  word is a repeat of the last good frame.
- IR_ERR  output  1  one-cycle pulse on any frame abort.
- IR_OVERRUN  output  1  one-cycle pulse when a completed frame is dropped.

Behaviour:
- Input path: 2-flop synchronizer on IR_IN; mark = ~synced. A third register gives edge detect. Edge-to-state latency is 3 FAB_CLK.
- Timing counters:
  - The prescaler counts 0..TICK_CYCLES-1.
  - The 8-bit tick counter increments on prescaler wrap and saturates at 255.
  - On every detected edge, both the prescaler and the tick counter clear to 0.
  - "width" is the tick count sampled at an edge.
- States: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK.
  - IDLE: a space-to-mark edge goes to LEAD_MARK. A stuck mark or stuck space stays in IDLE.
  - LEAD_MARK, at mark end: width 160..200 goes to LEAD_SPACE; otherwise error.
  - LEAD_SPACE, at mark start:
    - width 80..100: clear the shift register and bit count, set repeat=0, go to BIT_MARK.
    - width 38..52: set repeat=1, go to STOP_MARK.
    - otherwise error.
  - BIT_MARK, at mark end: width 8..14 goes to BIT_SPACE; otherwise error.
  - BIT_SPACE, at mark start:
    - width 8..14 shifts in 0; width 28..40 shifts in 1; otherwise error.
    - Bits are LSB first into a 32-bit register: byte0=addr, byte1=~addr, byte2=cmd, byte3=~cmd.
    - After the 32nd bit go to STOP_MARK; otherwise go to BIT_MARK.
  - STOP_MARK, at mark end: width 8..14 completes the frame; otherwise error.
  - Timeout: in any non-IDLE state, tick count reaching TIMEOUT_TICKS is an error.
- Completion:
  - repeat=0: require byte1==~byte0 and byte3==~byte2, else error. On pass, emit {addr,cmd} with IR_REPEAT=0, store it as last-good and set last_ok.
  - repeat=1: if last_ok, emit the stored last-good with IR_REPEAT=1; otherwise error.
  - Return to IDLE in all cases.
- Error: IR_ERR pulses high for 1 cycle and the FSM returns to IDLE. No output is produced and last-good is unchanged.
- Output register:
  - An emit loads IR_ADDR/IR_CMD/IR_REPEAT and sets IR_VALID.
  - Data is held stable while IR_VALID=1 and IR_READY=0.
  - A transfer (IR_VALID & IR_READY) clears IR_VALID the next cycle.
  - Emit in the same cycle as a transfer: load the new word and keep IR_VALID=1.
  - Emit while IR_VALID=1 with no transfer: drop the new word, pulse IR_OVERRUN, keep the old word.
- Reset (including mid-frame): FSM to IDLE, counters 0, last_ok=0.
  - IR_VALID, IR_ADDR, IR_CMD, IR_REPEAT, IR_ERR and IR_OVERRUN all reset to 0.
  - The synchronizer resets to 1 (space), so no spurious edge is seen at reset release.

Test Plan (TICK_CYCLES=4, tick = 4 clocks):
- Good frame addr=0x04, cmd=0x08: mark 180/space 90 ticks, 32 bits (mark 11; space 11 for 0, 34 for 1), stop mark 11 -> IR_VALID=1, IR_ADDR=0x04, IR_CMD=0x08, IR_REPEAT=0. Holds with IR_READY=0; clears the cycle after IR_READY=1.
- Repeat after the good frame: mark 180, space 45, mark 11 -> word 0x04/0x08 with IR_REPEAT=1. Repeat sent after reset with no prior frame -> IR_ERR pulse, no IR_VALID.
- Bad complement: byte3=0xF8 instead of 0xF7 -> single IR_ERR pulse, IR_VALID stays 0, and a following repeat emits the previous good word.
- Timing violations: leader mark 150 -> IR_ERR at mark end. Bit space 20 -> IR_ERR. Space held 230 ticks mid-frame -> IR_ERR at tick 220 and FSM back in IDLE. Next good frame decodes correctly in each case.
- Backpressure: two good frames with IR_READY=0 -> first word retained plus one IR_OVERRUN pulse. Then a completion in the same cycle as IR_READY=1 -> new word loaded, IR_VALID never drops.
- FAB_RESET asserted at bit 17 -> all outputs 0. Resume IR_IN mid-frame -> no output until a full leader. Next complete frame decodes correctly.

Source files
------------

// File: rtl/nec_ir_decoder.sv
// NEC IR frame decoder: synchronizes the demodulated IR input, times mark/space
// widths in 50 us ticks, decodes leader/data/stop/repeat and presents the
// address/command pair through a one-deep valid/ready output register.
module nec_ir_decoder #(
    parameter int unsigned TICK_CYCLES   = 2000,
    parameter int unsigned TIMEOUT_TICKS = 220
) (
    input  logic       FAB_CLK,
    input  logic       FAB_RESET,
    input  logic       IR_IN,
    input  logic       IR_READY,
    output logic       IR_VALID,
    output logic [7:0] IR_ADDR,
    output logic [7:0] IR_CMD,
    output logic       IR_REPEAT,
    output logic       IR_ERR,
    output logic       IR_OVERRUN
);

    localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned TW = 8;
    localparam int unsigned SW = 32;
    localparam int unsigned CW = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK
    } state_t;

    // Registered state
    logic          sync1_q, sync2_q, sync3_q;
    logic [PW-1:0] presc_q;
    logic [TW-1:0] tick_q;
    state_t        state_q;
    logic [SW-1:0] shift_q;
    logic [CW-1:0] bit_cnt_q;
    logic          rep_q;
    logic          last_ok_q;
    logic [7:0]    last_addr_q, last_cmd_q;
    logic          valid_q, orep_q, err_q, ovr_q;
    logic [7:0]    addr_q, cmd_q;

    // Next-state values
    logic          sync1_d, sync2_d, sync3_d;
    logic [PW-1:0] presc_d;
    logic [TW-1:0] tick_d;
    state_t        state_d;
    logic [SW-1:0] shift_d;
    logic [CW-1:0] bit_cnt_d;
    logic          rep_d;
    logic          last_ok_d;
    logic [7:0]    last_addr_d, last_cmd_d;
    logic          valid_d, orep_d, err_d, ovr_d;
    logic [7:0]    addr_d, cmd_d;

    // Combinational helpers
    logic          edge_c, mark_start_c, mark_end_c, timeout_c;
    logic          err_c, emit_c, emit_rep_c;
    logic [7:0]    emit_addr_c, emit_cmd_c;

    function automatic logic in_rng(input logic [7:0] w, input logic [7:0] lo,
                                    input logic [7:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

    // Synchronizer chain plus a third stage for edge detection
    always_comb begin
        sync1_d = IR_IN;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
    end

    // Line is active-low: sync2_q==0 means carrier (mark) present
    always_comb begin
        edge_c       = sync2_q ^ sync3_q;
        mark_start_c = edge_c & ~sync2_q;
        mark_end_c   = edge_c & sync2_q;
        timeout_c    = (tick_q >= TW'(TIMEOUT_TICKS));
    end

    // Prescaler and saturating tick counter, both cleared on every edge
    always_comb begin
        presc_d = presc_q;
        tick_d  = tick_q;
        if (edge_c) begin
            presc_d = '0;
            tick_d  = '0;
        end else if (presc_q == PW'(TICK_CYCLES - 1)) begin
            presc_d = '0;
            if (tick_q != {TW{1'b1}}) begin
                tick_d = tick_q + TW'(1);
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Frame FSM: next state, shift register, last-good store, emit/error strobes
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        rep_d       = rep_q;
        last_ok_d   = last_ok_q;
        last_addr_d = last_addr_q;
        last_cmd_d  = last_cmd_q;
        err_c       = 1'b0;
        emit_c      = 1'b0;
        emit_rep_c  = 1'b0;
        emit_addr_c = '0;
        emit_cmd_c  = '0;

        if ((state_q != S_IDLE) && !edge_c && timeout_c) begin
            err_c = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mark_start_c) state_d = S_LEAD_MARK;
                end
                S_LEAD_MARK: begin
                    if (mark_end_c) begin
                        if (in_rng(tick_q, 8'd160, 8'd200)) state_d = S_LEAD_SPACE;
                        else                                err_c   = 1'b1;
                    end
                end
                S_LEAD_SPACE: begin
                    if (mark_start_c) begin
                        if (in_rng(tick_q, 8'd80, 8'd100)) begin
                            shift_d   = '0;
                            bit_cnt_d = '0;
                            rep_d     = 1'b0;
                            state_d   = S_BIT_MARK;
                        end else if (in_rng(tick_q, 8'd38, 8'd52)) begin
                            rep_d   = 1'b1;
                            state_d = S_STOP_MARK;
                        end else begin
                            err_c = 1'b1;
                        end
                    end
                end
                S_BIT_MARK: begin
                    if (mark_end_c) begin
                        if (in_rng(tick_q, 8'd8, 8'd14)) state_d = S_BIT_SPACE;
                        else                             err_c   = 1'b1;
                    end
                end
                S_BIT_SPACE: begin
                    if (mark_start_c) begin
                        if (in_rng(tick_q, 8'd8, 8'd14) || in_rng(tick_q, 8'd28, 8'd40)) begin
                            // LSB first: new bit enters at the top and walks down
                            shift_d   = {in_rng(tick_q, 8'd28, 8'd40), shift_q[SW-1:1]};
                            bit_cnt_d = bit_cnt_q + CW'(1);
                            state_d   = (bit_cnt_q == CW'(SW - 1)) ? S_STOP_MARK : S_BIT_MARK;
                        end else begin
                            err_c = 1'b1;
                        end
                    end
                end
                S_STOP_MARK: begin
                    if (mark_end_c) begin
                        if (!in_rng(tick_q, 8'd8, 8'd14)) begin
                            err_c = 1'b1;
                        end else if (!rep_q) begin
                            if ((shift_q[15:8] == ~shift_q[7:0]) &&
                                (shift_q[31:24] == ~shift_q[23:16])) begin
                                emit_c      = 1'b1;
                                emit_addr_c = shift_q[7:0];
                                emit_cmd_c  = shift_q[23:16];
                                last_ok_d   = 1'b1;
                                last_addr_d = shift_q[7:0];
                                last_cmd_d  = shift_q[23:16];
                                state_d     = S_IDLE;
                            end else begin
                                err_c = 1'b1;
                            end
                        end else if (last_ok_q) begin
                            emit_c      = 1'b1;
                            emit_rep_c  = 1'b1;
                            emit_addr_c = last_addr_q;
                            emit_cmd_c  = last_cmd_q;
                            state_d     = S_IDLE;
                        end else begin
                            err_c = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (err_c) state_d = S_IDLE;
    end

    // One-deep output register with overrun detection
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        cmd_d   = cmd_q;
        orep_d  = orep_q;
        err_d   = err_c;
        ovr_d   = 1'b0;
        if (emit_c) begin
            if (!valid_q || IR_READY) begin
                valid_d = 1'b1;
                addr_d  = emit_addr_c;
                cmd_d   = emit_cmd_c;
                orep_d  = emit_rep_c;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && IR_READY) begin
            valid_d = 1'b0;
        end
    end

    // All state registers; synchronizer resets to the idle (space) level
    always_ff @(posedge FAB_CLK) begin
        if (FAB_RESET) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            sync3_q     <= 1'b1;
            presc_q     <= '0;
            tick_q      <= '0;
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            rep_q       <= 1'b0;
            last_ok_q   <= 1'b0;
            last_addr_q <= '0;
            last_cmd_q  <= '0;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            cmd_q       <= '0;
            orep_q      <= 1'b0;
            err_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
            presc_q     <= presc_d;
            tick_q      <= tick_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            rep_q       <= rep_d;
            last_ok_q   <= last_ok_d;
            last_addr_q <= last_addr_d;
            last_cmd_q  <= last_cmd_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            cmd_q       <= cmd_d;
            orep_q      <= orep_d;
            err_q       <= err_d;
            ovr_q       <= ovr_d;
        end
    end

    assign IR_VALID   = valid_q;
    assign IR_ADDR    = addr_q;
    assign IR_CMD     = cmd_q;
    assign IR_REPEAT  = orep_q;
    assign IR_ERR     = err_q;
    assign IR_OVERRUN = ovr_q;

endmodule

// File: tb/tb_nec_ir_decoder.sv
// Randomized self-checking bench for nec_ir_decoder with a frame-level reference model.
module tb_nec_ir_decoder;

    localparam int TICK = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       ir_in;
    logic       ir_ready;
    logic       ir_valid;
    logic [7:0] ir_addr;
    logic [7:0] ir_cmd;
    logic       ir_repeat;
    logic       ir_err;
    logic       ir_overrun;

    nec_ir_decoder #(.TICK_CYCLES(TICK), .TIMEOUT_TICKS(220)) dut (
        .FAB_CLK    (clk),
        .FAB_RESET  (rst),
        .IR_IN      (ir_in),
        .IR_READY   (ir_ready),
        .IR_VALID   (ir_valid),
        .IR_ADDR    (ir_addr),
        .IR_CMD     (ir_cmd),
        .IR_REPEAT  (ir_repeat),
        .IR_ERR     (ir_err),
        .IR_OVERRUN (ir_overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Observed events
    logic [31:0] got_q[$];
    int err_cnt  = 0;
    int ovr_cnt  = 0;
    int drop_cnt = 0;
    bit watch    = 1'b0;

    // Reference model state
    logic [31:0] exp_q[$];
    int          exp_err = 0;
    int          exp_ovr = 0;
    bit          last_ok = 1'b0;
    logic [15:0] last_w  = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: count pulses and record every completed transfer
    always @(negedge clk) begin
        if (ir_err) err_cnt++;
        if (ir_overrun) ovr_cnt++;
        if (ir_valid && ir_ready) got_q.push_back({15'd0, ir_repeat, ir_addr, ir_cmd});
        if (watch && !ir_valid) drop_cnt++;
    end

    function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
        return {~c, c, ~a, a};
    endfunction

    // Frame-level model: complement rule decides emit vs error
    task automatic model_frame(input logic [31:0] d);
        if ((d[15:8] == ~d[7:0]) && (d[31:24] == ~d[23:16])) begin
            exp_q.push_back({15'd0, 1'b0, d[7:0], d[23:16]});
            last_w  = {d[7:0], d[23:16]};
            last_ok = 1'b1;
        end else begin
            exp_err++;
        end
    endtask

    task automatic model_repeat();
        if (last_ok) exp_q.push_back({15'd0, 1'b1, last_w});
        else         exp_err++;
    endtask

    task automatic cmp_words(input string tag);
        chk({tag, "_cnt"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_word"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        chk({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
        chk({tag, "_ovr"}, 32'(ovr_cnt), 32'(exp_ovr));
    endtask

    // Drive a level for a number of ticks; always ends #1 after a rising edge
    task automatic seg(input logic lvl, input int ticks);
        ir_in = ~lvl;
        repeat (ticks * TICK) @(posedge clk);
        #1;
    endtask

    function automatic int rmk();
        return int'($urandom_range(9, 13));
    endfunction

    task automatic send_leader();
        seg(1'b1, int'($urandom_range(165, 195)));
        seg(1'b0, int'($urandom_range(85, 95)));
    endtask

    task automatic send_bits(input logic [31:0] d, input int from, input int to);
        for (int i = from; i <= to; i++) begin
            seg(1'b1, rmk());
            seg(1'b0, d[i] ? int'($urandom_range(30, 38)) : int'($urandom_range(9, 13)));
        end
    endtask

    // Full frame; optional one-cycle ready pulse aligned with the completion cycle
    task automatic send_frame(input logic [31:0] d, input bit rdy_pulse);
        send_leader();
        send_bits(d, 0, 31);
        seg(1'b1, rmk());
        ir_in = 1'b1;
        if (rdy_pulse) begin
            repeat (2) @(posedge clk);
            #1 ir_ready = 1'b1;
            @(posedge clk);
            #1 ir_ready = 1'b0;
        end
        seg(1'b0, 30);
    endtask

    task automatic send_repeat();
        seg(1'b1, int'($urandom_range(165, 195)));
        seg(1'b0, int'($urandom_range(40, 50)));
        seg(1'b1, rmk());
        seg(1'b0, 30);
    endtask

    task automatic send_bad_lead();
        seg(1'b1, int'($urandom_range(120, 150)));
        seg(1'b0, 60);
    endtask

    task automatic send_bad_space(input logic [31:0] d, input int b);
        send_leader();
        send_bits(d, 0, b - 1);
        seg(1'b1, rmk());
        seg(1'b0, int'($urandom_range(17, 24)));
        seg(1'b1, rmk());
        seg(1'b0, 30);
    endtask

    task automatic send_timeout(input logic [31:0] d, input int b, input string tag);
        send_leader();
        send_bits(d, 0, b - 1);
        seg(1'b1, rmk());
        seg(1'b0, 200);
        chk({tag, "_early"}, 32'(err_cnt), 32'(exp_err));
        seg(1'b0, 30);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid"}, 32'(ir_valid), 32'd0);
        chk({tag, "_addr"}, 32'(ir_addr), 32'd0);
        chk({tag, "_cmd"}, 32'(ir_cmd), 32'd0);
        chk({tag, "_rep"}, 32'(ir_repeat), 32'd0);
        chk({tag, "_err"}, 32'(ir_err), 32'd0);
        chk({tag, "_ovr"}, 32'(ir_overrun), 32'd0);
    endtask

    logic [31:0] d, da, db, dc, dp;
    int          kind;

    initial begin
        rst      = 1'b1;
        ir_in    = 1'b1;
        ir_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("post_reset_valid", 32'(ir_valid), 32'd0);
        chk("post_reset_err", 32'(err_cnt), 32'd0);

        // Repeat with no prior frame
        ir_ready = 1'b1;
        send_repeat();
        model_repeat();
        cmp_words("rep_noprior");

        // Good frame 0x04/0x08 held under backpressure
        ir_ready = 1'b0;
        d = mk(8'h04, 8'h08);
        send_frame(d, 1'b0);
        chk("good_valid", 32'(ir_valid), 32'd1);
        chk("good_addr", 32'(ir_addr), 32'h04);
        chk("good_cmd", 32'(ir_cmd), 32'h08);
        chk("good_rep", 32'(ir_repeat), 32'd0);
        repeat (50) @(posedge clk);
        #1;
        chk("hold_valid", 32'(ir_valid), 32'd1);
        chk("hold_addr", 32'(ir_addr), 32'h04);
        ir_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("clear_valid", 32'(ir_valid), 32'd0);
        model_frame(d);
        cmp_words("good");

        send_repeat();
        model_repeat();
        cmp_words("rep1");

        // Bad complement on byte3
        d = {8'hF8, 8'h08, 8'hFB, 8'h04};
        send_frame(d, 1'b0);
        model_frame(d);
        chk("badcomp_valid", 32'(ir_valid), 32'd0);
        cmp_words("badcomp");

        send_repeat();
        model_repeat();
        cmp_words("rep2");

        send_bad_lead();
        exp_err++;
        cmp_words("badlead");
        d = mk(8'($urandom), 8'($urandom));
        send_frame(d, 1'b0);
        model_frame(d);
        cmp_words("after_badlead");

        d = mk(8'($urandom), 8'($urandom));
        send_bad_space(d, int'($urandom_range(1, 31)));
        exp_err++;
        cmp_words("badspace");

        send_timeout(d, int'($urandom_range(1, 31)), "timeout");
        exp_err++;
        cmp_words("timeout");
        d = mk(8'($urandom), 8'($urandom));
        send_frame(d, 1'b0);
        model_frame(d);
        cmp_words("after_timeout");

        // Backpressure: second frame overruns, third lands on the transfer cycle
        ir_ready = 1'b0;
        da = mk(8'($urandom), 8'($urandom));
        db = mk(8'($urandom), 8'($urandom));
        dc = mk(8'($urandom), 8'($urandom));
        send_frame(da, 1'b0);
        model_frame(da);
        send_frame(db, 1'b0);
        exp_ovr++;
        chk("bp_keep_addr", 32'(ir_addr), 32'(da[7:0]));
        chk("bp_keep_cmd", 32'(ir_cmd), 32'(da[23:16]));
        watch = 1'b1;
        send_frame(dc, 1'b1);
        watch = 1'b0;
        chk("bp_new_valid", 32'(ir_valid), 32'd1);
        chk("bp_new_addr", 32'(ir_addr), 32'(dc[7:0]));
        chk("bp_new_cmd", 32'(ir_cmd), 32'(dc[23:16]));
        chk("bp_no_drop", 32'(drop_cnt), 32'd0);
        cmp_words("bp");

        // Reset in the middle of bit 17's mark, then resume the same frame
        dp = mk(8'($urandom), 8'($urandom));
        send_leader();
        send_bits(dp, 0, 16);
        ir_in = 1'b0;
        repeat (5 * TICK) @(posedge clk);
        #1;
        chk("pre_rst_valid", 32'(ir_valid), 32'd1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("midrst");
        repeat (5) @(posedge clk);
        #1;
        rst      = 1'b0;
        ir_ready = 1'b1;
        seg(1'b1, 6);
        seg(1'b0, dp[17] ? 34 : 11);
        send_bits(dp, 18, 31);
        seg(1'b1, 11);
        seg(1'b0, 30);
        chk("resume_noout", 32'(got_q.size()), 32'd0);
        chk("resume_valid", 32'(ir_valid), 32'd0);
        got_q.delete();
        exp_q.delete();
        exp_err = err_cnt;
        exp_ovr = ovr_cnt;
        last_ok = 1'b0;
        send_repeat();
        model_repeat();
        cmp_words("rep_after_rst");
        d = mk(8'($urandom), 8'($urandom));
        send_frame(d, 1'b0);
        model_frame(d);
        cmp_words("after_rst");

        // Random mix of frames against the model
        for (int n = 0; n < 6; n++) begin
            kind = int'($urandom_range(0, 6));
            d    = mk(8'($urandom), 8'($urandom));
            case (kind)
                0, 1: begin send_frame(d, 1'b0); model_frame(d); end
                2:    begin send_repeat(); model_repeat(); end
                3: begin
                    d = d ^ (32'd1 << ($urandom_range(0, 1) ? $urandom_range(8, 15)
                                                           : $urandom_range(24, 31)));
                    send_frame(d, 1'b0);
                    model_frame(d);
                end
                4: begin send_bad_lead(); exp_err++; end
                5: begin send_bad_space(d, int'($urandom_range(1, 31))); exp_err++; end
                default: begin send_timeout(d, int'($urandom_range(1, 31)), "rnd_to"); exp_err++; end
            endcase
            cmp_words($sformatf("rnd%0d_k%0d", n, kind));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
